roi_buffer_sequencer: RTL and testbench

ROI_BUFFER_SEQUENCER -- requirements
Module: roi_buffer_sequencer

---
 rtl/roi_buffer_sequencer_if.sv | 34 +++
 rtl/roi_buffer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_roi_buffer_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/roi_buffer_sequencer_if.sv
// ROI sequencer bus: pixel-stream control in, BRAM ping-pong control out.
// The stream source drives through master; the sequencer is the slave.
interface roi_buffer_sequencer_if;
    logic               in_extended_roi;
    logic               roi_end;
    logic               center_vsync;
    logic               point_valid;
    logic [11:0]        point_x0;
    logic [10:0]        point_y0;
    logic [9:0]         write_addr;
    logic [9:0]         read_addr;
    logic               we_a;
    logic               we_b;
    logic               bank_sel;
    logic               rd_en;
    logic               rd_oob;
    logic signed [16:0] read_offset;
    logic               busy;
    logic               frame_err;

    modport master (
        output in_extended_roi, roi_end, center_vsync,
        output point_valid, point_x0, point_y0,
        input  write_addr, read_addr, we_a, we_b, bank_sel,
        input  rd_en, rd_oob, read_offset, busy, frame_err
    );

    modport slave (
        input  in_extended_roi, roi_end, center_vsync,
        input  point_valid, point_x0, point_y0,
        output write_addr, read_addr, we_a, we_b, bank_sel,
        output rd_en, rd_oob, read_offset, busy, frame_err
    );
endinterface

// File: rtl/roi_buffer_sequencer.sv
// Ping-pong ROI buffer sequencer: writes the current ROI into one bank
// while reading the previous ROI, shifted by the point motion, from the other.
module roi_buffer_sequencer #(
    parameter int NEIGH_SIZE   = 10,
    parameter int BORDER_WIDTH = 2,
    parameter int READ_LATENCY = 2
) (
    input logic                   clk,
    input logic                   rst,
    roi_buffer_sequencer_if.slave bus
);
    localparam int WINDOW   = 2 * (NEIGH_SIZE + BORDER_WIDTH) + 1;
    localparam int ADDR_LIM = WINDOW * WINDOW - 1;
    localparam logic [9:0]         LIM10 = 10'(ADDR_LIM);
    localparam logic signed [17:0] LIM18 = 18'(ADDR_LIM);
    localparam logic [17:0]        LAT18 = 18'(READ_LATENCY);
    localparam logic [23:0]        WIN24 = 24'(WINDOW);

    typedef enum logic [2:0] {
        IDLE, FILL, WAIT_VSYNC, CALC1, CALC2, STREAM
    } state_t;

    state_t             state;
    logic               vs_q;
    logic               have_prev;
    logic [11:0]        pend_x, prev_x;
    logic [10:0]        pend_y, prev_y;
    logic signed [12:0] dx;
    logic signed [23:0] dy_mul;
    logic [9:0]         write_addr;
    logic signed [16:0] read_offset;
    logic               bank_sel;
    logic               frame_err;

    logic               vs_edge;
    logic               writing;
    logic               wr;
    logic [9:0]         wa_next;
    logic [11:0]        dy_c;
    logic [11:0]        new_x;
    logic [10:0]        new_y;
    logic signed [24:0] off_sum;
    logic signed [16:0] off_sat;
    logic signed [17:0] s;
    logic [9:0]         ra;
    logic               clamped;

    assign vs_edge = bus.center_vsync & ~vs_q;
    assign writing = (state == FILL) | (state == CALC1) |
                     (state == CALC2) | (state == STREAM);
    assign wr      = bus.in_extended_roi & writing;
    assign wa_next = (write_addr == LIM10) ? 10'd0 : write_addr + 10'd1;
    assign dy_c    = {1'b0, pend_y} - {1'b0, prev_y};
    assign new_x   = bus.point_valid ? bus.point_x0 : pend_x;
    assign new_y   = bus.point_valid ? bus.point_y0 : pend_y;

    // Offset sum with saturation to the 17-bit signed output range
    always_comb begin
        off_sum = {{12{dx[12]}}, dx} + {dy_mul[23], dy_mul};
        if (off_sum > 25'sd65535)
            off_sat = 17'sh0FFFF;
        else if (off_sum < -25'sd65536)
            off_sat = 17'sh10000;
        else
            off_sat = off_sum[16:0];
    end

    assign s = {8'd0, write_addr} + {read_offset[16], read_offset} + LAT18;

    // Read address clamp into the window; clamping marks out-of-bounds
    always_comb begin
        ra      = s[9:0];
        clamped = 1'b0;
        if (s[17]) begin
            ra      = 10'd0;
            clamped = 1'b1;
        end else if (s > LIM18) begin
            ra      = LIM10;
            clamped = 1'b1;
        end
    end

    assign bus.we_a        = wr & bank_sel;
    assign bus.we_b        = wr & ~bank_sel;
    assign bus.rd_en       = bus.in_extended_roi & (state == STREAM);
    assign bus.rd_oob      = bus.rd_en & clamped;
    assign bus.read_addr   = ra;
    assign bus.write_addr  = write_addr;
    assign bus.read_offset = read_offset;
    assign bus.bank_sel    = bank_sel;
    assign bus.busy        = (state == CALC1) | (state == CALC2);
    assign bus.frame_err   = frame_err;

    // Frame sequencing FSM with bank swap, address and offset registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            vs_q        <= 1'b0;
            have_prev   <= 1'b0;
            pend_x      <= '0;
            pend_y      <= '0;
            prev_x      <= '0;
            prev_y      <= '0;
            dx          <= '0;
            dy_mul      <= '0;
            write_addr  <= '0;
            read_offset <= '0;
            bank_sel    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vs_q      <= bus.center_vsync;
            frame_err <= 1'b0;
            if (bus.point_valid) begin
                pend_x <= bus.point_x0;
                pend_y <= bus.point_y0;
            end
            if (wr)
                write_addr <= wa_next;
            unique case (state)
                IDLE: begin
                    if (vs_edge)
                        state <= FILL;
                end
                FILL, STREAM: begin
                    if (bus.roi_end) begin
                        prev_x    <= new_x;
                        prev_y    <= new_y;
                        have_prev <= 1'b1;
                        state     <= WAIT_VSYNC;
                        if (vs_edge) begin
                            bank_sel   <= ~bank_sel;
                            write_addr <= '0;
                            state      <= CALC1;
                        end
                    end else if (vs_edge) begin
                        frame_err  <= 1'b1;
                        have_prev  <= 1'b0;
                        bank_sel   <= ~bank_sel;
                        write_addr <= '0;
                        state      <= FILL;
                    end
                end
                WAIT_VSYNC: begin
                    if (vs_edge) begin
                        bank_sel   <= ~bank_sel;
                        write_addr <= '0;
                        state      <= have_prev ? CALC1 : FILL;
                    end
                end
                CALC1: begin
                    dx     <= {1'b0, pend_x} - {1'b0, prev_x};
                    dy_mul <= {{12{dy_c[11]}}, dy_c} * WIN24;
                    if (vs_edge)
                        frame_err <= 1'b1;
                    state <= CALC2;
                end
                CALC2: begin
                    read_offset <= off_sat;
                    if (vs_edge)
                        frame_err <= 1'b1;
                    state <= STREAM;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_roi_buffer_sequencer.sv
// Scoreboard bench for roi_buffer_sequencer: every expected write/read
// beat is queued by the stimulus and popped by a negedge monitor.
module tb_roi_buffer_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    roi_buffer_sequencer_if bus ();

    roi_buffer_sequencer #(
        .NEIGH_SIZE  (10),
        .BORDER_WIDTH(2),
        .READ_LATENCY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       a;
        logic       b;
        logic [9:0] wa;
        logic       rd;
        logic [9:0] ra;
        logic       oob;
    } exp_t;

    exp_t q[$];
    exp_t mg;
    exp_t me;
    int   n_cmp = 0;
    int   n_err = 0;
    int   mwa   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat: bank, write address, read enable and clamped read address
    task automatic push_px(input bit a, input bit rd, input int off);
        exp_t e;
        int   s;
        s     = mwa + off + 2;
        e.a   = a;
        e.b   = !a;
        e.wa  = 10'(mwa);
        e.rd  = rd;
        e.oob = 1'b0;
        if (s < 0) begin
            e.ra  = 10'd0;
            e.oob = rd;
        end else if (s > 624) begin
            e.ra  = 10'd624;
            e.oob = rd;
        end else begin
            e.ra = 10'(s);
        end
        q.push_back(e);
        mwa = (mwa == 624) ? 0 : mwa + 1;
    endtask

    task automatic run_px(input int n, input bit a, input bit rd,
                          input int off);
        for (int i = 0; i < n; i++) begin
            bus.in_extended_roi = 1'b1;
            push_px(a, rd, off);
            tick();
        end
        bus.in_extended_roi = 1'b0;
    endtask

    task automatic vsync();
        bus.center_vsync = 1'b1;
        tick();
        bus.center_vsync = 1'b0;
    endtask

    task automatic roi_end_p();
        bus.roi_end = 1'b1;
        tick();
        bus.roi_end = 1'b0;
    endtask

    task automatic point(input int x, input int y);
        bus.point_valid = 1'b1;
        bus.point_x0    = 12'(x);
        bus.point_y0    = 11'(y);
        tick();
        bus.point_valid = 1'b0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_we_a"}, int'(bus.we_a), 0);
        chk({tag, "_we_b"}, int'(bus.we_b), 0);
        chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
        chk({tag, "_rd_oob"}, int'(bus.rd_oob), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_ferr"}, int'(bus.frame_err), 0);
        chk({tag, "_raddr"}, int'(bus.read_addr), 2);
        chk({tag, "_bank"}, int'(bus.bank_sel), 0);
        chk({tag, "_waddr"}, int'(bus.write_addr), 0);
        chk({tag, "_off"}, int'(bus.read_offset), 0);
    endtask

    // Monitor: each write beat is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (!rst && (bus.we_a || bus.we_b)) begin
            mg.a   = bus.we_a;
            mg.b   = bus.we_b;
            mg.wa  = bus.write_addr;
            mg.rd  = bus.rd_en;
            mg.ra  = bus.read_addr;
            mg.oob = bus.rd_oob;
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got a=%0b b=%0b wa=%0d, none queued",
                         mg.a, mg.b, mg.wa);
            end else begin
                me = q.pop_front();
                if (mg !== me) begin
                    n_err++;
                    $display("FAIL wr_beat: got a=%0b b=%0b wa=%0d rd=%0b ra=%0d oob=%0b want a=%0b b=%0b wa=%0d rd=%0b ra=%0d oob=%0b",
                             mg.a, mg.b, mg.wa, mg.rd, mg.ra, mg.oob,
                             me.a, me.b, me.wa, me.rd, me.ra, me.oob);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst                 = 1'b1;
        bus.in_extended_roi = 1'b0;
        bus.roi_end         = 1'b0;
        bus.center_vsync    = 1'b0;
        bus.point_valid     = 1'b0;
        bus.point_x0        = '0;
        bus.point_y0        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outs("reset");
        tick();
        rst = 1'b0;

        // First frame: fill only, bank B, 625 beats with wrap
        vsync();
        @(negedge clk);
        chk("fill_busy", int'(bus.busy), 0);
        chk("fill_bank", int'(bus.bank_sel), 0);
        point(100, 50);
        mwa = 0;
        run_px(625, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("wrap_waddr", int'(bus.write_addr), 0);
        roi_end_p();

        // Second frame: point moved (+2,-1) -> offset -23
        point(102, 49);
        vsync();
        @(negedge clk);
        chk("calc1_busy", int'(bus.busy), 1);
        tick();
        @(negedge clk);
        chk("calc2_busy", int'(bus.busy), 1);
        tick();
        @(negedge clk);
        chk("stream_busy", int'(bus.busy), 0);
        chk("off_m23", int'(bus.read_offset), -23);
        chk("bank_a", int'(bus.bank_sel), 1);
        mwa = 0;
        run_px(31, 1'b1, 1'b1, -23);
        roi_end_p();

        // Third frame: same point, writes during busy, top clamp
        vsync();
        mwa = 0;
        run_px(2, 1'b0, 1'b0, -23);
        @(negedge clk);
        chk("off_zero", int'(bus.read_offset), 0);
        run_px(623, 1'b0, 1'b1, 0);
        roi_end_p();

        // Fourth frame: vsync in STREAM without roi_end
        vsync();
        mwa = 0;
        tick();
        tick();
        run_px(5, 1'b1, 1'b1, 0);
        vsync();
        @(negedge clk);
        chk("ferr_pulse", int'(bus.frame_err), 1);
        chk("ferr_bank", int'(bus.bank_sel), 0);
        chk("ferr_waddr", int'(bus.write_addr), 0);
        tick();
        @(negedge clk);
        chk("ferr_clear", int'(bus.frame_err), 0);
        chk("ferr_busy", int'(bus.busy), 0);
        mwa = 0;
        run_px(3, 1'b0, 1'b0, 0);
        roi_end_p();

        // Fifth frame: roi_end + point_valid + vsync together
        vsync();
        mwa = 0;
        tick();
        tick();
        run_px(3, 1'b1, 1'b1, 0);
        bus.roi_end      = 1'b1;
        bus.point_valid  = 1'b1;
        bus.point_x0     = 12'd500;
        bus.point_y0     = 11'd300;
        bus.center_vsync = 1'b1;
        tick();
        bus.roi_end      = 1'b0;
        bus.point_valid  = 1'b0;
        bus.center_vsync = 1'b0;
        @(negedge clk);
        chk("combo_busy", int'(bus.busy), 1);
        chk("combo_bank", int'(bus.bank_sel), 0);
        chk("combo_ferr", int'(bus.frame_err), 0);
        tick();
        tick();
        @(negedge clk);
        chk("combo_off", int'(bus.read_offset), 0);
        mwa = 0;
        run_px(3, 1'b0, 1'b1, 0);

        // Asynchronous reset mid-STREAM
        bus.in_extended_roi = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk_idle_outs("async_rst");
        bus.in_extended_roi = 1'b0;
        tick();
        rst = 1'b0;

        // Frame after reset is a first frame again: no reads
        vsync();
        mwa = 0;
        run_px(3, 1'b0, 1'b0, 0);
        roi_end_p();
        tick();
        chk("queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
